// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port synchronous RAM.
// Optional out-of-range trapping is enabled by defining RAM_ARB_BOUNDS_CHECK_EN.
module ram_arbiter #(
  parameter int          ADDR_WIDTH = 5,
  parameter int          DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic                  rsp0_err,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic                  rsp1_err,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  if (DEPTH == 0 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
    $error("ram_arbiter: DEPTH must lie in 1 .. 2**ADDR_WIDTH");
  end

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  ram_re_q, ram_re_d;
  logic                  ram_we_q, ram_we_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;

  logic                  grant_any;
  logic                  grant_port;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  sel_oor;
  logic                  rsp_is_read;

  always_comb begin
    grant_any  = (state_q == IDLE) && (req0_valid || req1_valid);
    // On a tie the port that did not win last time takes the grant.
    if (req0_valid && req1_valid) grant_port = ~last_grant_q;
    else                          grant_port = req1_valid;
    sel_we    = grant_port ? req1_we    : req0_we;
    sel_addr  = grant_port ? req1_addr  : req0_addr;
    sel_wdata = grant_port ? req1_wdata : req0_wdata;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
    sel_oor   = (32'(sel_addr) >= DEPTH);
`else
    sel_oor   = 1'b0;
`endif
  end

  // Ready is combinational; rst masks it so it drops the moment reset asserts.
  assign req0_ready = grant_any && !grant_port && !rst;
  assign req1_ready = grant_any &&  grant_port && !rst;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    we_d          = we_q;
    err_d         = err_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    ram_re_d      = 1'b0;
    ram_we_d      = 1'b0;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          state_d       = ISSUE;
          owner_d       = grant_port;
          last_grant_d  = grant_port;
          we_d          = sel_we;
          err_d         = sel_oor;
          ram_addr_d    = sel_addr;
          ram_data_in_d = sel_wdata;
          ram_re_d      = !sel_we && !sel_oor;
          ram_we_d      =  sel_we && !sel_oor;
        end
      end
      ISSUE: begin
        state_d      = RESP;
        rsp0_valid_d = !owner_q;
        rsp1_valid_d =  owner_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      err_q         <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      ram_re_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      err_q         <= err_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_re_q      <= ram_re_d;
      ram_we_q      <= ram_we_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
    end
  end

  assign ram_addr         = ram_addr_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_write_enable = ram_we_q;

  // RAM read data arrives in RESP and is forwarded without another register stage.
  assign rsp_is_read = !we_q && !err_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rdata  = (rsp0_valid_q && rsp_is_read) ? ram_data_out : '0;
  assign rsp1_rdata  = (rsp1_valid_q && rsp_is_read) ? ram_data_out : '0;
  assign rsp0_err    = rsp0_valid_q && err_q;
  assign rsp1_err    = rsp1_valid_q && err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter with a behavioural one-cycle-latency RAM.
module tb_ram_arbiter;
  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef RAM_ARB_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid = 1'b0, req0_we = 1'b0, req1_valid = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_ready, req1_ready;
  logic          rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic          ram_read_enable, ram_write_enable;
  logic [DW-1:0] ram_data_out = '0;

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_data_out(ram_data_out)
  );

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            grant_port_log[$];
  int            grant_cyc_log[$];
  logic [DW-1:0] mem    [2**AW];
  logic [DW-1:0] shadow [2**AW];
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  exp_t          mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr] <= ram_data_in;
    if (ram_read_enable)  ram_data_out  <= mem[ram_addr];
  end

  // Response monitor: pops the scoreboard whenever a response pulse appears.
  always @(posedge clk) begin
    #1;
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      vectors++;
      if (rsp0_valid && rsp1_valid) begin
        miscompares++;
        $display("FAIL rsp_both actual rsp0_valid=1 rsp1_valid=1 required only one at cyc %0d", cyc);
      end else if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rsp_unexpected actual rsp%0d_valid=1 required no response at cyc %0d",
                 rsp1_valid, cyc);
      end else begin
        mon_e = sb.pop_front();
        if ((rsp1_valid !== mon_e.port) || (cyc != mon_e.due) ||
            ((mon_e.port ? rsp1_rdata : rsp0_rdata) !== mon_e.rdata) ||
            ((mon_e.port ? rsp1_err : rsp0_err) !== mon_e.err) ||
            ((mon_e.port ? rsp0_rdata : rsp1_rdata) !== '0) ||
            ((mon_e.port ? rsp0_err : rsp1_err) !== 1'b0) ||
            ram_read_enable !== 1'b0 || ram_write_enable !== 1'b0) begin
          miscompares++;
          $display("FAIL rsp actual port=%0d cyc=%0d rdata=%h err=%b other_rdata=%h re=%b we=%b required port=%0d cyc=%0d rdata=%h err=%b other_rdata=00 re=0 we=0",
                   rsp1_valid, cyc, mon_e.port ? rsp1_rdata : rsp0_rdata,
                   mon_e.port ? rsp1_err : rsp0_err, mon_e.port ? rsp0_rdata : rsp1_rdata,
                   ram_read_enable, ram_write_enable,
                   mon_e.port, mon_e.due, mon_e.rdata, mon_e.err);
        end
        if (mon_e.we && !mon_e.err) shadow[mon_e.addr] = mon_e.wdata;
      end
    end
  end

  task automatic drive_port(input int p, input logic v, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic issue(input int p, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input bit cut);
    bit   got;
    bit   oor;
    exp_t e;
    got = 1'b0;
    @(negedge clk);
    drive_port(p, 1'b1, we, a, d);
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if ((p == 0) ? req0_ready : req1_ready) got = 1'b1;
      else @(negedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL grant_timeout port=%0d actual ready=0 required ready=1 within 40 cycles", p);
      drive_port(p, 1'b0, 1'b0, '0, '0);
      return;
    end
    if (((p == 0) ? req1_ready : req0_ready) !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_exclusive port=%0d actual other_ready=1 required 0", p);
    end
    oor = BC && (a >= DEPTH);
    e.port  = (p != 0);
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    e.rdata = (we || oor) ? '0 : shadow[a];
    e.err   = oor;
    e.due   = cyc + 2;
    if (!cut) sb.push_back(e);
    grant_port_log.push_back(p);
    grant_cyc_log.push_back(cyc);

    @(negedge clk);
    vectors++;
    if (((p == 0) ? req0_ready : req1_ready) !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_pulse port=%0d actual ready=1 in ISSUE required 0", p);
    end
    if (cut) begin
      rst = 1'b1;
      #1;
      vectors++;
      if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
           ram_read_enable, ram_write_enable} !== 8'h00 ||
          rsp0_rdata !== '0 || rsp1_rdata !== '0 || ram_addr !== '0 || ram_data_in !== '0) begin
        miscompares++;
        $display("FAIL reset_cut actual rdy=%b%b rspv=%b%b re=%b we=%b addr=%h din=%h required all 0",
                 req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_read_enable,
                 ram_write_enable, ram_addr, ram_data_in);
      end
      sb.delete();
      drive_port(p, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    drive_port(p, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (ram_write_enable !== (we && !oor) || ram_read_enable !== (!we && !oor) ||
        (!oor && ram_addr !== a) || (we && !oor && ram_data_in !== d)) begin
      miscompares++;
      $display("FAIL issue port=%0d actual we=%b re=%b addr=%h din=%h required we=%b re=%b addr=%h din=%h",
               p, ram_write_enable, ram_read_enable, ram_addr, ram_data_in,
               we && !oor, !we && !oor, a, d);
    end
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rsp_missing actual pending=%0d required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err,
         ram_read_enable, ram_write_enable} !== 8'h00 ||
        rsp0_rdata !== '0 || rsp1_rdata !== '0 || ram_addr !== '0 || ram_data_in !== '0) begin
      miscompares++;
      $display("FAIL reset_values actual rdy=%b%b rspv=%b%b re=%b we=%b addr=%h din=%h required all 0",
               req0_ready, req1_ready, rsp0_valid, rsp1_valid, ram_read_enable,
               ram_write_enable, ram_addr, ram_data_in);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_tie_after_reset();
    grant_port_log.delete();
    grant_cyc_log.delete();
    fork
      issue(0, 1'b0, 5'd1, 8'h00, 1'b0);
      issue(1, 1'b0, 5'd2, 8'h00, 1'b0);
    join
    drain();
    vectors++;
    if (grant_port_log.size() != 2 || grant_port_log[0] != 0 || grant_port_log[1] != 1 ||
        grant_cyc_log[1] - grant_cyc_log[0] != 3) begin
      miscompares++;
      $display("FAIL tie_order actual grants=%0d first=%0d gap=%0d required 2 grants first=0 gap=3",
               grant_port_log.size(), grant_port_log.size() > 0 ? grant_port_log[0] : -1,
               grant_port_log.size() > 1 ? grant_cyc_log[1] - grant_cyc_log[0] : -1);
    end
  endtask

  task automatic test_write_read();
    issue(0, 1'b1, 5'd3, 8'hA5, 1'b0);
    issue(0, 1'b0, 5'd3, 8'h00, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    grant_port_log.delete();
    grant_cyc_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(0, (i % 2) == 0, 5'(8 + i), 8'($urandom_range(0, 255)), 1'b0);
      end
      begin
        for (int j = 0; j < 4; j++)
          issue(1, (j == 3), 5'(8 + j), 8'($urandom_range(0, 255)), 1'b0);
      end
    join
    drain();
    vectors++;
    if (grant_port_log.size() != 8) begin
      miscompares++;
      $display("FAIL b2b_count actual grants=%0d required 8", grant_port_log.size());
    end else begin
      for (int k = 1; k < 8; k++) begin
        vectors++;
        if (grant_port_log[k] == grant_port_log[k-1] ||
            grant_cyc_log[k] - grant_cyc_log[k-1] != 3) begin
          miscompares++;
          $display("FAIL b2b_alternate idx=%0d actual port=%0d gap=%0d required port=%0d gap=3",
                   k, grant_port_log[k], grant_cyc_log[k] - grant_cyc_log[k-1],
                   1 - grant_port_log[k-1]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    issue(0, 1'b1, 5'd5, 8'h11, 1'b0);
    drain();
    issue(0, 1'b1, 5'd5, 8'h3C, 1'b1);
    drain();
    issue(0, 1'b0, 5'd5, 8'h00, 1'b0);
    drain();
  endtask

  task automatic test_bounds();
    issue(1, 1'b1, 5'd20, 8'h77, 1'b0);
    issue(0, 1'b0, 5'd20, 8'h00, 1'b0);
    issue(1, 1'b0, 5'd15, 8'h00, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tie_after_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_write();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port synchronous `ram`. It lets two requesters share one memory: port 0 is the fetch side and port 1 is the load/store side. It drives the RAM's `addr`, `data_in`, `read_enable` and `write_enable` from registers. It returns read data to the winning requester after the RAM's one-cycle read latency. It sits between the core's memory-access units and the `ram` instance.

## Interface
- `ADDR_WIDTH`, default 5: address width; must match `ram`.
- `DATA_WIDTH`, default 8: data width; must match `ram`.
- `DEPTH`, default 16: number of RAM words; used only by the bounds check.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  request pending on port N.
- `req0_we`, `req1_we`  in  1  1 = write, 0 = read.
- `req0_addr`, `req1_addr`  in  ADDR_WIDTH  request address.
- `req0_wdata`, `req1_wdata`  in  DATA_WIDTH  write data.
- `req0_ready`, `req1_ready`  out  1  request accepted this cycle (combinational).
- `rsp0_valid`, `rsp1_valid`  out  1  one-cycle response pulse (registered).
- `rsp0_rdata`, `rsp1_rdata`  out  DATA_WIDTH  read data; 0 for writes and errors.
- `rsp0_err`, `rsp1_err`  out  1  out-of-range access; valid with `rspN_valid`.
- `ram_addr`  out  ADDR_WIDTH  to `ram.addr` (registered).
- `ram_data_in`  out  DATA_WIDTH  to `ram.data_in` (registered).
- `ram_read_enable`  out  1  to `ram.read_enable` (registered).
- `ram_write_enable`  out  1  to `ram.write_enable` (registered).
- `ram_data_out`  in  DATA_WIDTH  from `ram.data_out`.

## Operation
FSM states: IDLE, ISSUE, RESP.

- **IDLE**
  - If neither `reqN_valid` is set: stay in IDLE, all `ram_*` enables 0.
  - If exactly one is valid: grant that port.
  - If both are valid: grant the port not granted last. `last_grant` resets to 1, so port 0 wins the first tie.
  - On grant: assert `reqN_ready` for the winner only, latch `owner`, `we`, `addr` and `wdata`, update `last_grant`, and go to ISSUE.
  - The registered `ram_read_enable` or `ram_write_enable` (per `we`) becomes 1 in ISSUE, together with `ram_addr` and `ram_data_in`.
- **ISSUE**
  - RAM enables are held for exactly this one cycle.
  - The RAM samples them at the end of the cycle.
  - Go to RESP; enables are 0 in RESP.
- **RESP**
  - `rspN_valid` = 1 for the owner only.
  - Read: `rspN_rdata` = `ram_data_out`, passed through combinationally.
  - Write: `rspN_rdata` = 0.
  - Return to IDLE next cycle.
  - `reqN_ready` is 0 in ISSUE and RESP.

Handshake rules:
- A requester holds `valid`, `we`, `addr` and `wdata` stable until it sees `ready`.
- Responses have no back-pressure; the requester must take the response in the RESP cycle.
- A non-owner's `rsp_valid` is never asserted.
- The losing port's request stays pending and is granted in the next IDLE cycle (no starvation).

Reset:
- Asynchronous `rst` forces state to IDLE and `last_grant` to 1.
- All `ram_*` outputs, `rspN_*` outputs and `reqN_ready` go to 0 immediately.
- A write whose ISSUE cycle is cut by reset before the clock edge is not committed.
- No response is produced for an interrupted operation.

## Timing
- Request accepted in cycle A (`ready` = 1) → RAM enables in cycle A+1 → response in cycle A+2, for both reads and writes.
- Next grant is possible in cycle A+3. Peak throughput is one access per 3 cycles.
- With both ports continuously valid, grants alternate 0, 1, 0, 1 …, every 3 cycles.
- Reset values:
  - `req0_ready`, `req1_ready`: 0
  - `rsp0_valid`, `rsp1_valid`: 0
  - `rsp0_rdata`, `rsp1_rdata`: 0
  - `rsp0_err`, `rsp1_err`: 0
  - `ram_addr`, `ram_data_in`: 0
  - `ram_read_enable`, `ram_write_enable`: 0

## Configuration
- `RAM_ARB_BOUNDS_CHECK_EN` defined:
  - An accepted request with `addr` ≥ `DEPTH` does not assert either RAM enable in ISSUE.
  - In RESP it returns `rspN_err` = 1 and `rspN_rdata` = 0.
  - Latency is unchanged (response at A+2).
- Undefined:
  - No check is performed and `rspN_err` is tied 0.
  - The address goes to the RAM unmodified.

## Test plan
- Reset, then port 0 writes 0xA5 to addr 3; port 0 reads addr 3 → `ram_write_enable` high exactly one cycle; read response at A+2 with `rsp0_rdata` = 0xA5, `rsp0_err` = 0.
- Both ports read (addr 1, addr 2) in the first cycle after reset → port 0 granted first, port 1 granted 3 cycles later; `rsp1_valid` never pulses during port 0's response.
- Both ports hold valid for 12 cycles → grants strictly alternate 0, 1, 0, 1; each `ready` pulse is exactly one cycle.
- Assert `rst` mid-ISSUE of a write of 0x3C to addr 5 → all outputs 0 immediately; a later read of addr 5 returns the prior content, not 0x3C.
- With `RAM_ARB_BOUNDS_CHECK_EN`, `DEPTH` = 16, port 1 writes addr 20 → no RAM enable, `rsp1_err` = 1 at A+2; without the macro, the write reaches the RAM and `rsp1_err` = 0.
